// File: rtl/afifo_chain_if.sv
// Handshake bundle for afifo_chain: write side, read side, chunk-level readiness and misuse flag.
interface afifo_chain_if #(
   parameter int unsigned W = 8
) ();
   logic         w_trigger;
   logic [W-1:0] w_data;
   logic         w_ready;
   logic         r_trigger;
   logic [W-1:0] r_data;
   logic         r_ready;
   logic         prop_w_ready;
   logic         prop_r_ready;
   logic         err;

   modport master (
      output w_trigger, w_data, r_trigger,
      input  w_ready, r_data, r_ready, prop_w_ready, prop_r_ready, err
   );

   modport slave (
      input  w_trigger, w_data, r_trigger,
      output w_ready, r_data, r_ready, prop_w_ready, prop_r_ready, err
   );
endinterface

// File: rtl/afifo_chain.sv
// Single-clock FWFT FIFO of N banks x (4096/W) words with chunk-level readiness flags.
// Define AFIFO_CHAIN_ERR_EN to build the sticky misuse detector driving err.
module afifo_chain #(
   parameter int unsigned W = 8,
   parameter int unsigned N = 8
) (
   input logic          clk,
   input logic          rst_,
   afifo_chain_if.slave bus
);
   localparam int unsigned D   = 4096 / W;
   localparam int unsigned CAP = N * D;
   localparam int unsigned C   = (N / 2) * D;
   localparam int unsigned AW  = $clog2(CAP);
   localparam int unsigned CW  = $clog2(CAP + 1);
   localparam int unsigned DW  = $clog2(D);

   logic [W-1:0]  mem [N][D];
   logic [AW-1:0] wptr_q, rptr_q, wptr_d, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  rdata_q, rdata_d;
   logic          prop_w_q, prop_r_q;
   logic          w_ready, r_ready, do_w, do_r;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(CAP - 1)) ? '0 : p + AW'(1);
   endfunction

   assign w_ready = (cnt_q != CW'(CAP));
   assign r_ready = (cnt_q != '0);
   assign do_w    = bus.w_trigger & w_ready;
   assign do_r    = bus.r_trigger & r_ready;

   always_comb begin
      wptr_d  = do_w ? ptr_inc(wptr_q) : wptr_q;
      rptr_d  = do_r ? ptr_inc(rptr_q) : rptr_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      case ({do_w, do_r})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      // Head word comes from the write port when it lands exactly at the new read pointer.
      if (cnt_d != '0) begin
         if (do_w && (rptr_d == wptr_q)) begin
            rdata_d = bus.w_data;
         end else begin
            rdata_d = mem[rptr_d[AW-1:DW]][rptr_d[DW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_w) begin
         mem[wptr_q[AW-1:DW]][wptr_q[DW-1:0]] <= bus.w_data;
      end
   end

   // Chunk flags sample the pre-edge occupancy, so they trail w_ready/r_ready by one cycle.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         prop_w_q <= 1'b1;
         prop_r_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         prop_w_q <= (cnt_q <= CW'(CAP - C));
         prop_r_q <= (cnt_q >= CW'(C));
      end
   end

`ifdef AFIFO_CHAIN_ERR_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         err_q <= 1'b0;
      end else if ((bus.w_trigger && !w_ready) || (bus.r_trigger && !r_ready)) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.w_ready      = w_ready;
   assign bus.r_ready      = r_ready;
   assign bus.r_data       = rdata_q;
   assign bus.prop_w_ready = prop_w_q;
   assign bus.prop_r_ready = prop_r_q;
endmodule

// File: tb/tb_afifo_chain.sv
// Bench for afifo_chain: vector table, chunk fill/full/drain, wrap, random traffic, async reset.
module tb_afifo_chain;
   localparam int unsigned W   = 8;
   localparam int unsigned N   = 8;
   localparam int unsigned CAP = 4096;
   localparam int unsigned C   = 2048;

   logic clk = 1'b0;
   logic rst_ = 1'b0;

   afifo_chain_if #(.W(W)) bus ();

   afifo_chain #(.W(W), .N(N)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference model: a plain queue plus what the outputs should show.
   logic [W-1:0] q[$];
   logic [W-1:0] m_rdata = '0;
   int           m_prev = 0;
   logic         m_err = 1'b0;

   typedef struct {
      logic         wt;
      logic [W-1:0] wd;
      logic         rt;
      logic         e_wr;
      logic         e_rr;
      logic [W-1:0] e_rd;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic model_reset();
      q.delete();
      m_rdata = '0;
      m_prev  = 0;
      m_err   = 1'b0;
   endtask

   task automatic check_model();
      chk("w_ready", {31'd0, bus.w_ready}, {31'd0, q.size() < CAP});
      chk("r_ready", {31'd0, bus.r_ready}, {31'd0, q.size() > 0});
      chk("r_data", 32'(bus.r_data), 32'(m_rdata));
      chk("prop_w_ready", {31'd0, bus.prop_w_ready}, {31'd0, (CAP - m_prev) >= C});
      chk("prop_r_ready", {31'd0, bus.prop_r_ready}, {31'd0, m_prev >= C});
      chk("err", {31'd0, bus.err}, {31'd0, m_err});
   endtask

   task automatic step(input logic wt, input logic [W-1:0] wd, input logic rt);
      int sz;
      bus.w_trigger = wt;
      bus.w_data    = wd;
      bus.r_trigger = rt;
      @(posedge clk);
      sz = q.size();
`ifdef AFIFO_CHAIN_ERR_EN
      if ((wt && sz == CAP) || (rt && sz == 0)) m_err = 1'b1;
`endif
      if (rt && sz > 0) void'(q.pop_front());
      if (wt && sz < CAP) q.push_back(wd);
      m_prev = sz;
      if (q.size() > 0) m_rdata = q[0];
      #1;
      bus.w_trigger = 1'b0;
      bus.r_trigger = 1'b0;
      check_model();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] d;
      int           s;

      tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11};
      tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h22};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h22};
      tbl[4] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33};
      tbl[5] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h33};
      tbl[6] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h44};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h55};
      tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h55};

      bus.w_trigger = 1'b0;
      bus.w_data    = '0;
      bus.r_trigger = 1'b0;
      model_reset();
      #12;
      check_model();
      @(negedge clk);
      rst_ = 1'b1;

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].wt, tbl[i].wd, tbl[i].rt);
         chk($sformatf("tbl%0d_w_ready", i), {31'd0, bus.w_ready}, {31'd0, tbl[i].e_wr});
         chk($sformatf("tbl%0d_r_ready", i), {31'd0, bus.r_ready}, {31'd0, tbl[i].e_rr});
         chk($sformatf("tbl%0d_r_data", i), 32'(bus.r_data), 32'(tbl[i].e_rd));
      end

      // Chunk fill, then fill to full.
      for (int i = 0; i < CAP; i++) begin
         d = W'(i);
         step(1'b1, d, 1'b0);
         if (i == C - 1) begin
            chk("prop_r_lag", {31'd0, bus.prop_r_ready}, 32'd0);
            step(1'b0, '0, 1'b0);
            chk("prop_r_chunk", {31'd0, bus.prop_r_ready}, 32'd1);
            chk("prop_w_chunk", {31'd0, bus.prop_w_ready}, 32'd1);
         end
      end
      chk("full_w_ready", {31'd0, bus.w_ready}, 32'd0);
      step(1'b0, '0, 1'b0);
      chk("full_prop_w", {31'd0, bus.prop_w_ready}, 32'd0);
      step(1'b1, 8'hAA, 1'b0);
`ifdef AFIFO_CHAIN_ERR_EN
      chk("full_err", {31'd0, bus.err}, 32'd1);
`else
      chk("full_err", {31'd0, bus.err}, 32'd0);
`endif

      // Read and write while full: read taken, write dropped.
      chk("drain_head", 32'(bus.r_data), 32'd0);
      step(1'b1, 8'hBB, 1'b1);
      for (int i = 1; i < CAP; i++) begin
         chk("drain_data", 32'(bus.r_data), 32'(i % 256));
         step(1'b0, '0, 1'b1);
      end
      chk("drain_empty", {31'd0, bus.r_ready}, 32'd0);
      step(1'b0, '0, 1'b1);
      chk("drain_extra", {31'd0, bus.r_ready}, 32'd0);

      // Three chunks through the buffer with overlapping read and write.
      s = 0;
      for (int i = 0; i < C; i++) begin
         step(1'b1, W'(s * 7 + 3), 1'b0);
         s++;
      end
      for (int i = 0; i < 2 * C; i++) begin
         step(1'b1, W'(s * 7 + 3), 1'b1);
         s++;
         chk("wrap_prop_r", {31'd0, bus.prop_r_ready}, 32'd1);
         chk("wrap_prop_w", {31'd0, bus.prop_w_ready}, 32'd1);
      end
      for (int i = 0; i < C; i++) step(1'b0, '0, 1'b1);
      chk("wrap_empty", {31'd0, bus.r_ready}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 45);
      end

      // Asynchronous reset between edges after a chunk is resident.
      for (int i = 0; i < C + 50; i++) step(1'b1, W'($urandom), 1'b0);
      #2;
      rst_ = 1'b0;
      model_reset();
      #1;
      chk("areset_r_ready", {31'd0, bus.r_ready}, 32'd0);
      chk("areset_w_ready", {31'd0, bus.w_ready}, 32'd1);
      chk("areset_prop_r", {31'd0, bus.prop_r_ready}, 32'd0);
      chk("areset_prop_w", {31'd0, bus.prop_w_ready}, 32'd1);
      chk("areset_r_data", 32'(bus.r_data), 32'd0);
      chk("areset_err", {31'd0, bus.err}, 32'd0);
      @(negedge clk);
      rst_ = 1'b1;
      step(1'b1, 8'h5A, 1'b0);
      step(1'b1, 8'h6B, 1'b0);
      chk("post_reset_first", 32'(bus.r_data), 32'h5A);
      step(1'b0, '0, 1'b1);
      chk("post_reset_second", 32'(bus.r_data), 32'h6B);
      step(1'b0, '0, 1'b1);
      chk("post_reset_empty", {31'd0, bus.r_ready}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/afifo_chain.md
AFIFO_CHAIN -- requirements
Module: afifo_chain

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_.
REQ-002 Parameter W SHALL default to 8 and set the word width; legal values are 1, 2, 4, 8 and 16.
REQ-003 Parameter N SHALL default to 8 and set the bank count; it must be even and at least 2.
REQ-004 Derived constants: D = 4096/W words per bank; capacity CAP = N*D; chunk C = (N/2)*D. Defaults give D=512, CAP=4096, C=2048.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_  input  1  asynchronous active-low reset.
REQ-007 w_trigger  input  1  write request.
REQ-008 w_data  input  W  write word.
REQ-009 w_ready  output  1  high when occupancy < CAP.
REQ-010 r_trigger  input  1  read (pop) request.
REQ-011 r_data  output  W  head word, first-word-fall-through; valid while r_ready.
REQ-012 r_ready  output  1  high when occupancy > 0.
REQ-013 prop_w_ready  output  1  high when free space >= C, i.e. a whole chunk may be written without checking w_ready.
REQ-014 prop_r_ready  output  1  high when occupancy >= C, i.e. a whole chunk may be read without checking r_ready.
REQ-015 err  output  1  sticky misuse flag (see Configuration).

Function
REQ-016 Storage SHALL be one circular buffer of CAP words, made of N banks of D words, using read and write pointers modulo CAP and an occupancy count of width clog2(CAP+1).
REQ-017 A write SHALL occur on an edge where w_trigger && w_ready: mem[wptr] <= w_data, then wptr increments, wrapping CAP-1 -> 0.
REQ-018 A write request while !w_ready SHALL be dropped, leaving storage and pointers unchanged.
REQ-019 A read SHALL occur on an edge where r_trigger && r_ready: rptr increments with wrap, and r_data presents the next word from the cycle after that edge.
REQ-020 A read request while !r_ready SHALL be ignored.
REQ-021 Simultaneous accepted read and write SHALL leave occupancy unchanged.
REQ-022 When full, w_ready is 0 and a write in the same cycle as a read is still dropped.
REQ-023 When empty, r_ready is 0 and a same-cycle read is ignored while the write is accepted.
REQ-024 w_ready and r_ready SHALL reflect occupancy after the most recent edge; a word written on edge k is readable (r_ready=1, r_data valid) in the cycle after edge k.
REQ-025 prop_w_ready and prop_r_ready SHALL be registered and update on the edge after the occupancy change, one cycle later than w_ready and r_ready.
REQ-026 Data order SHALL be strictly FIFO; no word is duplicated or lost across pointer wrap.
REQ-027 r_data SHALL hold its value while !r_ready, with no X-propagation requirement on its content.

Reset
REQ-028 On rst_ low, immediately and independent of clk: wptr=0, rptr=0, occupancy=0, err=0, r_data=0.
REQ-029 Outputs during and after reset: w_ready=1, r_ready=0, prop_w_ready=1, prop_r_ready=0.
REQ-030 Reset mid-operation SHALL discard all stored words.
REQ-031 The first accepted write SHALL be the first edge with rst_ high.

Configuration
REQ-032 Macro AFIFO_CHAIN_ERR_EN SHALL control the misuse flag.
REQ-033 With AFIFO_CHAIN_ERR_EN defined, err sets on any edge with (w_trigger && !w_ready) or (r_trigger && !r_ready), and stays set until reset.
REQ-034 Without AFIFO_CHAIN_ERR_EN, err SHALL be tied 0 and no detection logic is built.

Verification
REQ-035 Chunk fill (defaults): after reset write 0..2047 in consecutive cycles -> w_ready stays 1, prop_r_ready rises one cycle after the 2048th write, prop_w_ready is still 1 (free space 2048 >= C).
REQ-036 Fill to full: 4096 writes -> w_ready=0 and prop_w_ready=0; write 0xAA while full is dropped, and err=1 when AFIFO_CHAIN_ERR_EN is defined.
REQ-037 Drain: pop 4096 words -> r_data sequence matches the writes exactly (byte value = index mod 256), then r_ready=0; a further pop is ignored.
REQ-038 Wrap: cycle 3 chunks of 2048 through the buffer with concurrent read and write -> no loss or reorder, and occupancy is constant during overlap.
REQ-039 Async reset: assert rst_ mid-chunk between clock edges -> r_ready=0 and w_ready=1 without waiting for a clk edge; the next read after refill returns the first post-reset word.
